// File: rtl/comm_pkg.sv
// Shared constants, receiver state encoding and PRBS-7 step for the serial link.
package comm_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam logic [6:0]  LFSR_SEED_DEF  = 7'h7F;

  // x^7 + x^6 + 1: feedback taps on the two top stages
  localparam int unsigned LFSR_TAP_A = 6;
  localparam int unsigned LFSR_TAP_B = 5;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // One PRBS-7 advance: shift left, feedback into bit 0
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/comm_receiver.sv
// Start-bit locked UART receiver emitting each recovered data bit as it is sampled.
module comm_receiver
  import comm_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_line,
  output logic data
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  rx_state_e     state;
  logic [TW-1:0] timer;
  logic [BW-1:0] nbits;
  logic          half_c;
  logic          full_c;

  assign half_c = (timer == TW'(OVERSAMPLE / 2 - 1));
  assign full_c = (timer == TW'(OVERSAMPLE - 1));

  // Receiver FSM; the falling-edge detect clock counts as the first clock of the start bit
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state <= RX_HUNT;
      timer <= '0;
      nbits <= '0;
      data  <= 1'b0;
    end else begin
      case (state)
        RX_HUNT: begin
          if (rx_line) state <= RX_IDLE;
        end
        RX_IDLE: begin
          if (!rx_line) begin
            state <= RX_START;
            timer <= TW'(1);
          end
        end
        RX_START: begin
          if (half_c) begin
            timer <= '0;
            nbits <= '0;
            state <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RX_DATA: begin
          if (full_c) begin
            timer <= '0;
            data  <= rx_line;
            if (nbits == BW'(DATA_BITS - 1)) state <= RX_STOP;
            else                             nbits <= nbits + BW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RX_STOP: begin
          if (full_c) begin
            timer <= '0;
            state <= rx_line ? RX_IDLE : RX_HUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= RX_HUNT;
      endcase
    end
  end

endmodule

// File: rtl/comm_transmitter.sv
// PRBS-7 source framed UART-style: idle bit after reset, then start/data/stop back-to-back.
module comm_transmitter
  import comm_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter logic [6:0]  LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tx_line
);

  localparam int unsigned CW       = $clog2(OVERSAMPLE + 1);
  // Bit slot encoding: 0 idle, 1 start, 2..DATA_BITS+1 data, DATA_BITS+2 stop
  localparam int unsigned POS_STOP = DATA_BITS + 2;
  localparam int unsigned PW       = $clog2(POS_STOP + 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] pos;
  logic [6:0]    lfsr;
  logic          bit_end_c;
  logic [PW-1:0] pos_next_c;

  // The idle slot runs one clock longer because the reset edge already drove it high
  always_comb begin
    bit_end_c  = (pos == '0) ? (cnt == CW'(OVERSAMPLE)) : (cnt == CW'(OVERSAMPLE - 1));
    pos_next_c = (pos == PW'(POS_STOP)) ? PW'(1) : pos + PW'(1);
  end

  // Bit timer, slot sequencer and LFSR; the line value is registered at each slot boundary
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      tx_line <= 1'b1;
      cnt     <= '0;
      pos     <= '0;
      lfsr    <= LFSR_SEED;
    end else if (bit_end_c) begin
      cnt <= '0;
      pos <= pos_next_c;
      if (pos_next_c == PW'(1)) begin
        tx_line <= 1'b0;
      end else if (pos_next_c == PW'(POS_STOP)) begin
        tx_line <= 1'b1;
      end else begin
        tx_line <= lfsr[6];
        lfsr    <= prbs7_next(lfsr);
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/comm_system.sv
// Serial link top: PRBS-7 transmitter, one-cycle line delay, and receiver on one clock.
module comm_system
  import comm_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter logic [6:0]  LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic receiver_LO,
  input  logic transmitter_rst,
  input  logic receiver_rst,
  output logic receiver_data_o
);

  logic tx_line;
  logic rx_line;

  comm_transmitter #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS),
    .LFSR_SEED (LFSR_SEED)
  ) u_tx (
    .clk    (receiver_LO),
    .rst    (transmitter_rst),
    .tx_line(tx_line)
  );

  // Channel model: reset-free single-cycle delay so the receiver always sees a driven line
  always_ff @(posedge receiver_LO) begin
    rx_line <= tx_line;
  end

  comm_receiver #(
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS (DATA_BITS)
  ) u_rx (
    .clk    (receiver_LO),
    .rst    (receiver_rst),
    .rx_line(rx_line),
    .data   (receiver_data_o)
  );

endmodule

// File: tb/tb_comm_system.sv
// Directed and randomized checks of the PRBS-7 serial link against a bit-sequence model.
module tb_comm_system;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int FP = (DB + 2) * OS;

  logic clk = 1'b0;
  logic tx_rst;
  logic rx_rst;
  logic data_o;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic prbs [0:2047];

  comm_system dut (
    .receiver_LO    (clk),
    .transmitter_rst(tx_rst),
    .receiver_rst   (rx_rst),
    .receiver_data_o(data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  task automatic chk(input logic got, input logic exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Data bit k of frame f must appear exactly at T+OS*(k+1)+OS/2+1, previous value one clock before
  task automatic check_frames(input int t0, input int f0, input int f1, input string tag);
    for (int f = f0; f <= f1; f++) begin
      for (int k = 0; k < DB; k++) begin
        int e;
        int n;
        e = t0 + FP * f + OS * (k + 1) + OS / 2 + 1;
        n = DB * f + k;
        if (!(f == f0 && k == 0)) begin
          wait_until(e - 1);
          chk(data_o, prbs[n - 1], {tag, "_hold"});
        end
        wait_until(e);
        chk(data_o, prbs[n], tag);
      end
    end
  endtask

  task automatic toggle_phase(input int n, input logic rx_low, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(logic'($isunknown(data_o)), 1'b0, {tag, "_no_x"});
      if (rx_low) chk(data_o, 1'b0, {tag, "_zero"});
    end
  endtask

  initial begin
    logic [6:0] seed;
    int c0, t0, f, g, r, base;
    int unsigned off;

    // Reference stream: first seven bits are the seed MSB-first, then s[n] = s[n-7] ^ s[n-6]
    seed = 7'h7F;
    for (int i = 0; i < 7; i++) prbs[i] = seed[6 - i];
    for (int i = 7; i < 2048; i++) prbs[i] = prbs[i - 7] ^ prbs[i - 6];

    tx_rst = 1'b0;
    rx_rst = 1'b0;
    step();
    step();
    chk(dut.tx_line, 1'b1, "rst_tx_line");
    chk(data_o, 1'b0, "rst_data");

    // Both resets released together
    tx_rst = 1'b1;
    rx_rst = 1'b1;
    c0 = cyc + 1;
    t0 = c0 + OS;
    wait_until(t0 - 1);
    chk(dut.tx_line, 1'b1, "idle_high");
    wait_until(t0);
    chk(dut.tx_line, 1'b0, "first_start");
    check_frames(t0, 0, 1, "t1_frame");

    // Both resets asserted together take effect on the next edge
    tx_rst = 1'b0;
    rx_rst = 1'b0;
    step();
    chk(dut.tx_line, 1'b1, "both_rst_tx");
    chk(data_o, 1'b0, "both_rst_rx");
    step();

    // Receiver released 300 cycles after the transmitter
    tx_rst = 1'b1;
    c0 = cyc + 1;
    t0 = c0 + OS;
    for (int i = 0; i < 300; i++) begin
      step();
      chk(data_o, 1'b0, "rx_held");
    end
    rx_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk(data_o, 1'b0, "rx_release_hold");
    end
    check_frames(t0, 12, 136, "t2_prbs");

    // Transmitter reset pulsed for 20 cycles at a random point mid-frame
    f = 138;
    off = $urandom_range(140, 20);
    wait_until(t0 + FP * f + int'(off));
    tx_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk(dut.tx_line, 1'b1, "tx_rst_line");
    end
    tx_rst = 1'b1;
    c0 = cyc + 1;
    t0 = c0 + OS;
    wait_until(t0 - 1);
    chk(dut.tx_line, 1'b1, "t3_idle_high");
    wait_until(t0);
    chk(dut.tx_line, 1'b0, "t3_start");
    for (int k = 0; k < DB; k++) begin
      wait_until(t0 + OS * (k + 1) + OS / 2);
      chk(dut.tx_line, prbs[k], "tx_restart");
    end
    check_frames(t0, 2, 4, "t3_relock");

    // Transmitter reset toggled low/high/low/high, 100 cycles each
    tx_rst = 1'b0;
    toggle_phase(100, 1'b0, "t5_tx_lo1");
    tx_rst = 1'b1;
    toggle_phase(100, 1'b0, "t5_tx_hi1");
    tx_rst = 1'b0;
    toggle_phase(100, 1'b0, "t5_tx_lo2");
    tx_rst = 1'b1;
    c0 = cyc + 1;
    t0 = c0 + OS;
    check_frames(t0, 2, 5, "t5_tx");

    // Receiver reset toggled; final release lands at a random point in a stop bit
    rx_rst = 1'b0;
    toggle_phase(100, 1'b1, "t5_rx_lo1");
    rx_rst = 1'b1;
    toggle_phase(100, 1'b0, "t5_rx_hi1");
    rx_rst = 1'b0;
    toggle_phase(100, 1'b1, "t5_rx_lo2");
    f = (cyc - t0) / FP + 2;
    r = t0 + FP * f + int'($urandom_range(156, 146));
    while (cyc < r - 1) begin
      step();
      chk(data_o, 1'b0, "t5_rx_lo_tail");
    end
    rx_rst = 1'b1;
    while (cyc < t0 + FP * (f + 1) + OS + OS / 2) begin
      step();
      chk(data_o, 1'b0, "rx_wait_lock");
    end
    check_frames(t0, f + 1, f + 3, "t5_rx");

    // Three-cycle low glitch on the line while the receiver sits in IDLE
    g = f + 5;
    base = t0 + FP * g;
    wait_until(base + OS * (DB + 1) + OS / 2 + 1);
    force dut.rx_line = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(data_o, prbs[DB * g + DB - 1], "glitch_during");
    end
    release dut.rx_line;
    while (cyc < base + FP + OS + OS / 2) begin
      step();
      chk(data_o, prbs[DB * g + DB - 1], "glitch_hold");
    end
    check_frames(t0, g + 1, g + 2, "t6_after_glitch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
